// File: rtl/apb_fifo_periph.sv
// APB slave exposing a 32-bit FIFO as CTRL/STATUS/DATA registers, one wait state per transfer.
// Optional feature macro APB_FIFO_IRQ_EN: adds the irq output and stores CTRL.THRESH.
module apb_fifo_periph #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
`ifdef APB_FIFO_IRQ_EN
    output logic        irq,
`endif
    output logic        PREADY
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DATA   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic               udf;
    logic               empty;
    logic               full;
    logic               irq_bit;
    logic [3:0]         thresh;
    logic [31:0]        status;

    logic               push;
    logic               pop;
    logic               ctrl_wr;
    logic               rd_load;
    logic               pready_nxt;
    logic [31:0]        rdata_nxt;

    logic               unused;
    assign unused = ^{PADDR[31:4], PADDR[1:0]};

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign status = {16'h0, 8'(count), 3'b000, irq_bit, udf, ovf, full, empty};

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: a transfer is picked up at its setup phase and aborted if PSEL drops before DONE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (PSEL) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!PSEL)        state_nxt = S_IDLE;
                else if (PENABLE) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Register actions fire only on the WAIT->DONE edge, so a held PENABLE never repeats them
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        ctrl_wr    = 1'b0;
        rd_load    = 1'b0;
        rdata_nxt  = '0;
        pready_nxt = (state_nxt == S_DONE);
        if (state == S_WAIT && state_nxt == S_DONE) begin
            if (PWRITE) begin
                push    = (PADDR[3:2] == A_DATA);
                ctrl_wr = (PADDR[3:2] == A_CTRL);
            end else begin
                rd_load = 1'b1;
                case (PADDR[3:2])
                    A_CTRL:   rdata_nxt = {20'h0, thresh, 8'h0};
                    A_STATUS: rdata_nxt = status;
                    A_DATA: begin
                        pop       = 1'b1;
                        rdata_nxt = empty ? 32'h0 : mem[rd_ptr];
                    end
                    default:  rdata_nxt = '0;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            PREADY <= pready_nxt;
            if (rd_load) PRDATA <= rdata_nxt;
            if (push) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    count  <= count + CNT_W'(1);
                end
            end
            if (pop) begin
                if (empty) begin
                    udf <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    count  <= count - CNT_W'(1);
                end
            end
            if (ctrl_wr) begin
                if (PWDATA[0]) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end
                if (PWDATA[1]) begin
                    ovf <= 1'b0;
                    udf <= 1'b0;
                end
            end
        end
    end

    // Storage has no reset; contents are meaningless once the pointers are cleared
    always_ff @(posedge PCLK) begin
        if (push && !full) mem[wr_ptr] <= PWDATA;
    end

`ifdef APB_FIFO_IRQ_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            thresh <= 4'h0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) thresh <= PWDATA[11:8];
            irq <= (thresh != 4'h0) && (32'(count) >= 32'(thresh));
        end
    end
    assign irq_bit = irq;
`else
    assign thresh  = 4'h0;
    assign irq_bit = 1'b0;
`endif

endmodule

// File: tb/tb_apb_fifo_periph.sv
// Self-checking bench for apb_fifo_periph: directed scenarios plus random traffic against a queue model.
module tb_apb_fifo_periph;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h1000_1000;
`ifdef APB_FIFO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        pclk;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
`ifdef APB_FIFO_IRQ_EN
    logic        irq;
`endif

    int n_cmp;
    int n_bad;

    apb_fifo_periph #(.DEPTH(DEPTH)) dut (
        .PCLK    (pclk),
        .PRESET  (preset),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
`ifdef APB_FIFO_IRQ_EN
        .irq     (irq),
`endif
        .PREADY  (pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: a queue plus sticky flags and the last value the bus returned
    logic [31:0] q[$];
    bit          m_ovf;
    bit          m_udf;
    logic [3:0]  m_thresh;
    logic [31:0] m_prdata;

    task automatic m_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_thresh = 4'h0;
        m_prdata = 32'h0;
    endtask

    function automatic logic [31:0] m_status();
        int          n;
        logic [31:0] s;
        n = q.size();
        s = 32'(n) << 8;
        if (n == 0)                                        s = s | 32'h1;
        if (n == DEPTH)                                    s = s | 32'h2;
        if (m_ovf)                                         s = s | 32'h4;
        if (m_udf)                                         s = s | 32'h8;
        if (IRQ_EN && m_thresh != 0 && n >= int'(m_thresh)) s = s | 32'h10;
        return s;
    endfunction

    task automatic model(input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                         output logic [31:0] exp);
        if (wr) begin
            case (idx)
                2'd0: begin
                    if (wd[0]) q.delete();
                    if (wd[1]) begin m_ovf = 1'b0; m_udf = 1'b0; end
                    if (IRQ_EN) m_thresh = wd[11:8];
                end
                2'd2: if (q.size() == DEPTH) m_ovf = 1'b1; else q.push_back(wd);
                default: ;
            endcase
        end else begin
            case (idx)
                2'd0: m_prdata = IRQ_EN ? {20'h0, m_thresh, 8'h0} : 32'h0;
                2'd1: m_prdata = m_status();
                2'd2: begin
                    if (q.size() == 0) begin m_udf = 1'b1; m_prdata = 32'h0; end
                    else m_prdata = q.pop_front();
                end
                default: m_prdata = 32'h0;
            endcase
        end
        exp = m_prdata;
    endtask

    // Setup + access phases; returns which access cycle showed PREADY (-1 if none)
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat     = -1;
        rdata   = 32'hx;
        for (int c = 1; c <= 8; c++) begin
            if (pready === 1'b1) begin
                lat   = c;
                rdata = prdata;
                break;
            end
            @(posedge pclk); #1;
        end
        if (lat > 0) begin
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL bus_timeout: addr %h got no PREADY, want PREADY within 8 access cycles", addr);
        end
    endtask

    task automatic bus(input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                       output logic [31:0] got, output logic [31:0] exp, output int lat);
        apb_xfer(wr, BASE | (32'(idx) << 2), wd, got, lat);
        model(wr, idx, wd, exp);
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        int          lat;
        #1 preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL reset_pready: got %b want 0", pready); end
        n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        preset = 1'b0;
        m_reset();
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0001) begin n_bad++; $display("FAIL reset_status: got %h want 00000001", got); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ready_latency: got %0d want 2", lat); end
        n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL ready_one_cycle: got %b want 0", pready); end
    endtask

    task automatic test_fifo_order();
        logic [31:0] got, exp;
        int          lat;
        for (int i = 1; i <= 3; i++) bus(1'b1, 2'd2, 32'hA5A5_0000 + 32'(i), got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0001) begin n_bad++; $display("FAIL write_keeps_prdata: got %h want 00000001", got); end
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0300) begin n_bad++; $display("FAIL status_3: got %h want 00000300", got); end
        for (int i = 1; i <= 3; i++) begin
            bus(1'b0, 2'd2, 32'h0, got, exp, lat);
            n_cmp++; if (got !== 32'hA5A5_0000 + 32'(i)) begin n_bad++; $display("FAIL order_%0d: got %h want %h", i, got, 32'hA5A5_0000 + 32'(i)); end
        end
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0001) begin n_bad++; $display("FAIL status_drained: got %h want 00000001", got); end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        int          lat;
        for (int i = 1; i <= 9; i++) bus(1'b1, 2'd2, 32'hA5A5_0000 + 32'(i), got, exp, lat);
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0806) begin n_bad++; $display("FAIL status_full: got %h want 00000806", got); end
        for (int i = 1; i <= 8; i++) begin
            bus(1'b0, 2'd2, 32'h0, got, exp, lat);
            n_cmp++; if (got !== 32'hA5A5_0000 + 32'(i)) begin n_bad++; $display("FAIL ovf_read_%0d: got %h want %h", i, got, 32'hA5A5_0000 + 32'(i)); end
        end
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0005) begin n_bad++; $display("FAIL ovf_sticky: got %h want 00000005", got); end
        bus(1'b1, 2'd0, 32'h2, got, exp, lat);
    endtask

    task automatic test_underflow();
        logic [31:0] got, exp;
        int          lat;
        bus(1'b0, 2'd2, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL underflow_data: got %h want 0", got); end
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0009) begin n_bad++; $display("FAIL status_udf: got %h want 00000009", got); end
        bus(1'b1, 2'd0, 32'h2, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0009) begin n_bad++; $display("FAIL ctrl_write_prdata: got %h want 00000009", got); end
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0001) begin n_bad++; $display("FAIL clrerr: got %h want 00000001", got); end
    endtask

    task automatic test_flush_wrap();
        logic [31:0] got, exp, w;
        int          lat;
        for (int i = 0; i < 5; i++) bus(1'b1, 2'd2, $urandom, got, exp, lat);
        bus(1'b1, 2'd0, 32'h1, got, exp, lat);
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0001) begin n_bad++; $display("FAIL flush: got %h want 00000001", got); end
        for (int i = 0; i < 21; i++) begin
            w = $urandom;
            bus(1'b1, 2'd2, w, got, exp, lat);
            bus(1'b0, 2'd2, 32'h0, got, exp, lat);
            n_cmp++; if (got !== w) begin n_bad++; $display("FAIL wrap_pair_%0d: got %h want %h", i, got, w); end
        end
    endtask

    task automatic test_psel_drop();
        logic [31:0] got, exp;
        int          lat;
        bit          saw;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE | 32'h8; pwdata = $urandom;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(posedge pclk); #1;
            if (pready !== 1'b0) saw = 1'b1;
        end
        penable = 1'b0;
        n_cmp++; if (saw) begin n_bad++; $display("FAIL psel_drop_ready: got PREADY=1 want 0"); end
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL psel_drop_status: got %h want %h", got, exp); end
    endtask

`ifdef APB_FIFO_IRQ_EN
    task automatic test_irq();
        logic [31:0] got, exp, w;
        int          lat;
        bus(1'b1, 2'd0, 32'h1, got, exp, lat);
        bus(1'b1, 2'd0, 32'h300, got, exp, lat);
        for (int i = 0; i < 2; i++) bus(1'b1, 2'd2, $urandom, got, exp, lat);
        repeat (2) @(posedge pclk);
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_below: got %b want 0", irq); end
        w = $urandom;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE | 32'h8; pwdata = w;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1;
        n_cmp++; if (pready !== 1'b1 || irq !== 1'b0) begin n_bad++; $display("FAIL irq_at_ready: got ready=%b irq=%b want ready=1 irq=0", pready, irq); end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_after_ready: got %b want 1", irq); end
        model(1'b1, 2'd2, w, exp);
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0310) begin n_bad++; $display("FAIL irq_status: got %h want 00000310", got); end
        bus(1'b0, 2'd2, 32'h0, got, exp, lat);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] got, exp, wd;
        logic [1:0]  idx;
        int          lat, r;
        bit          wr;
        for (int i = 0; i < 300; i++) begin
            r   = $urandom_range(0, 9);
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            idx = (r < 6) ? 2'd2 : 2'(r - 6);
            if (idx == 2'd0 && $urandom_range(0, 7) != 0) wd[0] = 1'b0;
            bus(wr, idx, wd, got, exp, lat);
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rand_%0d: wr=%0d reg=%0d got %h want %h", i, wr, idx, got, exp); end
            n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rand_lat_%0d: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        int          lat;
        bus(1'b1, 2'd0, 32'h103, got, exp, lat);
        for (int i = 0; i < 2; i++) bus(1'b1, 2'd2, $urandom, got, exp, lat);
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL pre_reset_status: got %h want %h", got, exp); end
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE | 32'h8; pwdata = $urandom;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #3;
        preset = 1'b1;
        #1;
        n_cmp++; if (pready !== 1'b0 || prdata !== 32'h0) begin n_bad++; $display("FAIL async_reset: got ready=%b prdata=%h want 0/0", pready, prdata); end
`ifdef APB_FIFO_IRQ_EN
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL async_reset_irq: got %b want 0", irq); end
`endif
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        m_reset();
        bus(1'b0, 2'd1, 32'h0, got, exp, lat);
        n_cmp++; if (got !== 32'h0000_0001) begin n_bad++; $display("FAIL post_reset_status: got %h want 00000001", got); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        m_reset();
        test_reset();
        test_fifo_order();
        test_overflow();
        test_underflow();
        test_flush_wrap();
        test_psel_drop();
`ifdef APB_FIFO_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
